mmul_loop_sequencer: RTL and testbench
======================================

# mmul_loop_sequencer

Loop-nest sequencer for the BRAM-based matrix-multiply datapath. It issues the k-outer / i-middle / j-inner read-address stream for the A, B and C BRAMs and the matching C write-back address stream. It also provides the START/DONE handshake and a stall input. The datapath computes `C[wb_addr] = A*B + (rd_first ? 0 : C)` from the 1-cycle-latency BRAM read data; this sequencer holds no data.

## Interface
Parameters:
- LOG_ORDER, default 6: log2 of matrix order. order = 2**LOG_ORDER; LOG_ORDER >= 1 is required.
- AW, default 2*LOG_ORDER: BRAM address width. Must equal 2*LOG_ORDER.

Ports:
- CLK  in  1  clock; single clock domain, all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  start request; sampled only in IDLE.
- STALL  in  1  suppresses issue this cycle; counters hold.
- BUSY  out  1  combinational; high when state != IDLE.
- DONE  out  1  registered; one-cycle completion pulse.
- rd_valid  out  1  combinational; high when state == RUN and STALL == 0.
- a_rd_addr  out  AW  {i,k}, from counter registers.
- b_rd_addr  out  AW  {k,j}.
- c_rd_addr  out  AW  {i,j}.
- rd_first  out  1  combinational; high when k == 0 (datapath uses 0 instead of C).
- wb_enable  out  1  registered copy of rd_valid.
- wb_addr  out  AW  registered copy of c_rd_addr.
- wb_first  out  1  registered copy of rd_first.

## Operation
- Counters i, j, k are each LOG_ORDER bits. Each counter resets to 0.
- States are IDLE, RUN and DRAIN.
- IDLE:
  - START = 1 moves to RUN and clears i, j, k.
  - START = 0 stays in IDLE.
- RUN:
  - On every edge where rd_valid = 1, j increments.
  - When j wraps from order-1 to 0, i increments.
  - When i wraps, k increments.
  - The edge that issues tuple (order-1, order-1, order-1) moves to DRAIN. All counters return to 0.
  - Edges where rd_valid = 0 leave state and counters unchanged.
- DRAIN lasts exactly one cycle; wb_enable carries the last issue. The next edge moves to IDLE and sets DONE = 1 for one cycle.
- Issue count per run is exactly order**3, regardless of stalls.
- The write-back stage is never stalled, because BRAM read data always arrives one cycle after issue. So wb_* at edge e+1 always reflects the rd_* values of cycle e.
- No C read-after-write hazard exists: a given C address is re-read order**2 >= 4 issues after its write-back. No bypass is required.
- Address arithmetic is pure concatenation; order is a power of two, so no multiply is needed.
- START is ignored in RUN and DRAIN; no queuing.
- STALL is ignored outside RUN.
- RST in any state, including mid-run or DRAIN:
  - next cycle is IDLE;
  - i, j, k = 0;
  - wb_enable = 0, wb_addr = 0, wb_first = 0, DONE = 0;
  - any in-flight write-back is dropped.

## Timing
- Reset values: BUSY = 0, DONE = 0, rd_valid = 0, all addresses 0, rd_first = 1 (k = 0), wb_enable = 0, wb_first = 0.
- START is high at edge E0 in IDLE. Then:
  - cycle 1: BUSY = 1; rd_valid = 1 if STALL = 0; addresses are for (k,i,j) = (0,0,0).
- With no stalls, N = order**3:
  - rd_valid is high in cycles 1..N;
  - wb_enable is high in cycles 2..N+1;
  - cycle N+1 is DRAIN;
  - cycle N+2 has DONE = 1 and BUSY = 0.
- Each stalled RUN cycle shifts every later event by one cycle.
- START high in the DONE cycle (N+2) is accepted. RUN begins at N+3 with no dead cycle beyond that.
- A STALL in the final RUN cycle holds the last tuple; DRAIN follows its eventual issue.

## Test plan
- Basic order-2 run: LOG_ORDER = 1, pulse START, no STALL.
  - a_rd_addr = 0,0,2,2,1,1,3,3
  - b_rd_addr = 0,1,0,1,2,3,2,3
  - c_rd_addr = 0,1,2,3,0,1,2,3
  - rd_first = 1,1,1,1,0,0,0,0
  - wb_addr = the c sequence delayed by 1 cycle
  - DONE in cycle 10, BUSY low in cycle 10
- Stall handling: same run with STALL high during cycles 3-5.
  - rd_valid is low in those cycles and the address is held at tuple index 2.
  - wb_enable is low in cycles 4-6.
  - The sequence is unchanged; DONE moves to cycle 13.
- START while busy: START held high throughout. The run is unaffected; a second run starts the cycle after DONE.
- Reset mid-run: RST in cycle 5 of an order-2 run.
  - Cycle 6: BUSY = 0, wb_enable = 0, rd_valid = 0, no DONE.
  - A following START restarts at tuple (0,0,0).
- Full order: LOG_ORDER = 6 with random STALL at 30% density.
  - Exactly 262144 rd_valid cycles and 262144 wb_enable cycles.
  - Each C address is written 64 times; wb_first is high for exactly the first 4096 write-backs.
  - A scoreboard confirms the product against a reference multiply.

Source files
------------

// File: rtl/mmul_loop_sequencer.sv
// Loop-nest sequencer for the BRAM matrix-multiply datapath: issues the
// k/i/j read-address stream and the one-cycle-delayed C write-back stream.
module mmul_loop_sequencer #(
  parameter int unsigned LOG_ORDER = 6,
  parameter int unsigned AW        = 2 * LOG_ORDER
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          STALL,
  output logic          BUSY,
  output logic          DONE,
  output logic          rd_valid,
  output logic [AW-1:0] a_rd_addr,
  output logic [AW-1:0] b_rd_addr,
  output logic [AW-1:0] c_rd_addr,
  output logic          rd_first,
  output logic          wb_enable,
  output logic [AW-1:0] wb_addr,
  output logic          wb_first
);

  localparam logic [LOG_ORDER-1:0] CNT_MAX = '1;
  localparam logic [LOG_ORDER-1:0] CNT_ONE = LOG_ORDER'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [LOG_ORDER-1:0] i_q, i_d;
  logic [LOG_ORDER-1:0] j_q, j_d;
  logic [LOG_ORDER-1:0] k_q, k_d;
  logic                 done_q, done_d;
  logic                 wb_enable_q, wb_enable_d;
  logic [AW-1:0]        wb_addr_q, wb_addr_d;
  logic                 wb_first_q, wb_first_d;

  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = done_q;
  assign rd_valid  = (state_q == ST_RUN) && !STALL;
  assign a_rd_addr = {i_q, k_q};
  assign b_rd_addr = {k_q, j_q};
  assign c_rd_addr = {i_q, j_q};
  assign rd_first  = (k_q == '0);
  assign wb_enable = wb_enable_q;
  assign wb_addr   = wb_addr_q;
  assign wb_first  = wb_first_q;

  // Next-state, counter advance and write-back capture.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    done_d      = 1'b0;
    wb_enable_d = rd_valid;
    wb_addr_d   = c_rd_addr;
    wb_first_d  = rd_first;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RUN;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      ST_RUN: begin
        if (rd_valid) begin
          // Counters wrap naturally to 0 after the final tuple.
          j_d = j_q + CNT_ONE;
          if (j_q == CNT_MAX) begin
            i_d = i_q + CNT_ONE;
            if (i_q == CNT_MAX) begin
              k_d = k_q + CNT_ONE;
              if (k_q == CNT_MAX) begin
                state_d = ST_DRAIN;
              end
            end
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      done_q      <= 1'b0;
      wb_enable_q <= 1'b0;
      wb_addr_q   <= '0;
      wb_first_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      done_q      <= done_d;
      wb_enable_q <= wb_enable_d;
      wb_addr_q   <= wb_addr_d;
      wb_first_q  <= wb_first_d;
    end
  end

endmodule

// File: tb/tb_mmul_loop_sequencer.sv
// Self-checking bench: exact order-2 sequences plus a randomly stalled
// order-16 run feeding a datapath model checked against a reference multiply.
module tb_mmul_loop_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Order-2 instance
  logic       s_rst, s_start, s_stall;
  logic       s_busy, s_done, s_rd_valid, s_rd_first, s_wb_enable, s_wb_first;
  logic [1:0] s_a, s_b, s_c, s_wb_addr;

  mmul_loop_sequencer #(.LOG_ORDER(1), .AW(2)) u_small (
    .CLK(CLK), .RST(s_rst), .START(s_start), .STALL(s_stall),
    .BUSY(s_busy), .DONE(s_done), .rd_valid(s_rd_valid),
    .a_rd_addr(s_a), .b_rd_addr(s_b), .c_rd_addr(s_c), .rd_first(s_rd_first),
    .wb_enable(s_wb_enable), .wb_addr(s_wb_addr), .wb_first(s_wb_first)
  );

  // Order-16 instance
  localparam int BO = 16;
  localparam int BN = BO * BO * BO;
  logic       b_rst, b_start, b_stall;
  logic       b_busy, b_done, b_rd_valid, b_rd_first, b_wb_enable, b_wb_first;
  logic [7:0] b_a, b_b, b_c, b_wb_addr;

  mmul_loop_sequencer #(.LOG_ORDER(4), .AW(8)) u_big (
    .CLK(CLK), .RST(b_rst), .START(b_start), .STALL(b_stall),
    .BUSY(b_busy), .DONE(b_done), .rd_valid(b_rd_valid),
    .a_rd_addr(b_a), .b_rd_addr(b_b), .c_rd_addr(b_c), .rd_first(b_rd_first),
    .wb_enable(b_wb_enable), .wb_addr(b_wb_addr), .wb_first(b_wb_first)
  );

  int a_tab[8] = '{0, 0, 2, 2, 1, 1, 3, 3};
  int b_tab[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
  int c_tab[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int f_tab[8] = '{1, 1, 1, 1, 0, 0, 0, 0};

  task automatic test_reset();
    s_rst = 1'b1; s_start = 1'b0; s_stall = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_stall = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    tests++; if (s_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", s_busy); end
    tests++; if (s_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", s_done); end
    tests++; if (s_rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %b exp 0", s_rd_valid); end
    tests++; if ({s_a, s_b, s_c} !== 6'd0) begin fails++; $display("FAIL reset_addr got %h exp 0", {s_a, s_b, s_c}); end
    tests++; if (s_rd_first !== 1'b1) begin fails++; $display("FAIL reset_rd_first got %b exp 1", s_rd_first); end
    tests++; if ({s_wb_enable, s_wb_first, s_wb_addr} !== 4'd0) begin fails++; $display("FAIL reset_wb got %h exp 0", {s_wb_enable, s_wb_first, s_wb_addr}); end
    tests++; if ({b_busy, b_done, b_wb_enable} !== 3'd0) begin fails++; $display("FAIL reset_big got %b exp 000", {b_busy, b_done, b_wb_enable}); end
    @(negedge CLK);
    s_rst = 1'b0; b_rst = 1'b0;
    #1;
    tests++; if (s_busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy got %b exp 0", s_busy); end
  endtask

  // One order-2 run from IDLE; STALL high in cycles lo..hi; returns DONE cycle.
  task automatic run_small(input int lo, input int hi, input bit hold, output int done_c);
    int idx, prev_idx, drain_c;
    bit exp_iss, prev_iss;
    int phase; // 0 run, 1 drain, 2 done
    idx = 0; prev_idx = 0; prev_iss = 1'b0; drain_c = -1; done_c = -1;
    @(negedge CLK);
    s_start = 1'b1; s_stall = 1'b0;
    #1;
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      @(negedge CLK);
      s_start = hold;
      s_stall = (c >= lo) && (c <= hi);
      #1;
      if (idx < 8) phase = 0;
      else if (drain_c < 0) begin phase = 1; drain_c = c; end
      else phase = 2;
      exp_iss = (phase == 0) && !s_stall;
      tests++; if (s_rd_valid !== exp_iss) begin fails++; $display("FAIL rd_valid c%0d got %b exp %b", c, s_rd_valid, exp_iss); end
      tests++; if (s_wb_enable !== prev_iss) begin fails++; $display("FAIL wb_enable c%0d got %b exp %b", c, s_wb_enable, prev_iss); end
      tests++; if (s_done !== (phase == 2)) begin fails++; $display("FAIL done c%0d got %b exp %b", c, s_done, phase == 2); end
      tests++; if (s_busy !== (phase != 2)) begin fails++; $display("FAIL busy c%0d got %b exp %b", c, s_busy, phase != 2); end
      if (prev_iss) begin
        tests++; if (int'(s_wb_addr) != c_tab[prev_idx]) begin fails++; $display("FAIL wb_addr c%0d got %0d exp %0d", c, s_wb_addr, c_tab[prev_idx]); end
        tests++; if (int'(s_wb_first) != f_tab[prev_idx]) begin fails++; $display("FAIL wb_first c%0d got %b exp %0d", c, s_wb_first, f_tab[prev_idx]); end
      end
      if (phase == 0) begin
        tests++;
        if (int'(s_a) != a_tab[idx] || int'(s_b) != b_tab[idx] || int'(s_c) != c_tab[idx] || int'(s_rd_first) != f_tab[idx]) begin
          fails++;
          $display("FAIL rd_addr c%0d got a%0d b%0d c%0d f%b exp a%0d b%0d c%0d f%0d", c, s_a, s_b, s_c, s_rd_first,
                   a_tab[idx], b_tab[idx], c_tab[idx], f_tab[idx]);
        end
      end
      prev_iss = exp_iss;
      prev_idx = idx;
      if (exp_iss) idx++;
      if (phase == 2) done_c = c;
    end
    s_start = 1'b0; s_stall = 1'b0;
  endtask

  task automatic test_basic();
    int dc;
    run_small(0, -1, 1'b0, dc);
    tests++; if (dc != 10) begin fails++; $display("FAIL basic_done_cycle got %0d exp 10", dc); end
  endtask

  task automatic test_stall();
    int dc;
    run_small(3, 5, 1'b0, dc);
    tests++; if (dc != 13) begin fails++; $display("FAIL stall_done_cycle got %0d exp 13", dc); end
  endtask

  task automatic test_start_held();
    int dc;
    run_small(0, -1, 1'b1, dc);
    tests++; if (dc != 10) begin fails++; $display("FAIL held_done_cycle got %0d exp 10", dc); end
    s_start = 1'b1;
    @(negedge CLK);
    s_start = 1'b0;
    #1;
    tests++;
    if (s_busy !== 1'b1 || s_rd_valid !== 1'b1 || {s_a, s_b, s_c} !== 6'd0 || s_rd_first !== 1'b1) begin
      fails++;
      $display("FAIL held_restart got busy%b v%b addr%h exp busy1 v1 addr0", s_busy, s_rd_valid, {s_a, s_b, s_c});
    end
    @(negedge CLK);
    s_rst = 1'b1;
    @(negedge CLK);
    s_rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    s_start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      s_start = 1'b0;
      s_rst = (c == 5);
    end
    @(negedge CLK);
    s_rst = 1'b0;
    #1;
    tests++;
    if (s_busy !== 1'b0 || s_wb_enable !== 1'b0 || s_rd_valid !== 1'b0 || s_done !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid got busy%b wb%b v%b done%b exp all 0", s_busy, s_wb_enable, s_rd_valid, s_done);
    end
    s_start = 1'b1;
    @(negedge CLK);
    s_start = 1'b0;
    #1;
    tests++;
    if (s_rd_valid !== 1'b1 || {s_a, s_b, s_c} !== 6'd0 || s_rd_first !== 1'b1) begin
      fails++;
      $display("FAIL rst_restart got v%b addr%h exp v1 addr0", s_rd_valid, {s_a, s_b, s_c});
    end
    @(negedge CLK);
    #1;
    tests++; if (s_wb_enable !== 1'b1 || s_wb_addr !== 2'd0 || s_b !== 2'd1) begin fails++; $display("FAIL rst_second got wb%b wba%0d b%0d exp 1 0 1", s_wb_enable, s_wb_addr, s_b); end
    s_rst = 1'b1;
    @(negedge CLK);
    s_rst = 1'b0;
  endtask

  // Randomly stalled order-16 run with a datapath model and reference multiply.
  task automatic test_random_full();
    int am[BO*BO], bm[BO*BO], cm[BO*BO], wcnt[BO*BO];
    int idx, rd_n, wb_n, pend, bad, ref_v, ei, ej, ek;
    bit prev_iss, exp_iss, done_seen;
    for (int n = 0; n < BO * BO; n++) begin
      am[n] = int'($urandom_range(255)); bm[n] = int'($urandom_range(255));
      cm[n] = 0; wcnt[n] = 0;
    end
    idx = 0; rd_n = 0; wb_n = 0; pend = 0; prev_iss = 1'b0; done_seen = 1'b0;
    @(negedge CLK);
    b_start = 1'b1; b_stall = 1'b0;
    #1;
    for (int cyc = 0; cyc < 20000 && !done_seen; cyc++) begin
      @(negedge CLK);
      b_start = 1'b0;
      b_stall = ($urandom_range(99) < 30);
      #1;
      exp_iss = (idx < BN) && !b_stall && b_busy;
      tests++; if (b_rd_valid !== exp_iss) begin fails++; $display("FAIL big_rd_valid idx%0d got %b exp %b", idx, b_rd_valid, exp_iss); end
      tests++; if (b_wb_enable !== prev_iss) begin fails++; $display("FAIL big_wb_enable idx%0d got %b exp %b", idx, b_wb_enable, prev_iss); end
      if (b_wb_enable) begin
        tests++; if (b_wb_first !== (wb_n < BO * BO)) begin fails++; $display("FAIL big_wb_first n%0d got %b exp %b", wb_n, b_wb_first, wb_n < BO * BO); end
        cm[b_wb_addr] = pend;
        wcnt[b_wb_addr]++;
        wb_n++;
      end
      if (exp_iss) begin
        ek = idx / (BO * BO); ei = (idx / BO) % BO; ej = idx % BO;
        tests++;
        if (int'(b_a) != ei * BO + ek || int'(b_b) != ek * BO + ej || int'(b_c) != ei * BO + ej || b_rd_first !== (ek == 0)) begin
          fails++;
          $display("FAIL big_addr idx%0d got a%0d b%0d c%0d f%b exp a%0d b%0d c%0d", idx, b_a, b_b, b_c, b_rd_first,
                   ei * BO + ek, ek * BO + ej, ei * BO + ej);
        end
      end
      if (b_rd_valid) begin
        pend = am[b_a] * bm[b_b] + (b_rd_first ? 0 : cm[b_c]);
        rd_n++;
      end
      prev_iss = exp_iss;
      if (exp_iss) idx++;
      if (b_done) done_seen = 1'b1;
    end
    tests++; if (!done_seen) begin fails++; $display("FAIL big_done_timeout got 0 exp 1"); end
    tests++; if (rd_n != BN) begin fails++; $display("FAIL big_rd_count got %0d exp %0d", rd_n, BN); end
    tests++; if (wb_n != BN) begin fails++; $display("FAIL big_wb_count got %0d exp %0d", wb_n, BN); end
    bad = 0;
    for (int n = 0; n < BO * BO; n++) if (wcnt[n] != BO) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL big_per_addr_writes got %0d bad exp 0", bad); end
    bad = 0;
    for (int i = 0; i < BO; i++)
      for (int j = 0; j < BO; j++) begin
        ref_v = 0;
        for (int k = 0; k < BO; k++) ref_v += am[i * BO + k] * bm[k * BO + j];
        if (cm[i * BO + j] != ref_v) bad++;
      end
    tests++; if (bad != 0) begin fails++; $display("FAIL big_product got %0d wrong elements exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_start_held();
    test_reset_mid();
    test_basic();
    test_random_full();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
